slice_column_sequencer: RTL and testbench
=========================================

// Module: slice_column_sequencer
// PURPOSE
//  Initiator side of the slice-height handshake: walks screen columns 0..NUM_COLS-1, issues
//  column_count + begin_calc to find_slice_height, waits for end_calc, latches slice_size and
//  streams one vertical slice (ceiling / wall / floor) to the VGA adapter as x,y,colour,plot.
//  Sits between the frame controller (start_frame/frame_done) and the VGA adapter.
// PARAMETERS
//  NUM_COLS      160     columns per frame (x range 0..NUM_COLS-1)
//  SCREEN_H      120     rows per column (y range 0..SCREEN_H-1)
//  CALC_TIMEOUT  1023    max cycles waited for end_calc before forcing height 0
//  CEIL_COLOUR   3'b001  colour above wall span
//  WALL_COLOUR   3'b111  colour inside wall span
//  FLOOR_COLOUR  3'b010  colour below wall span
// PORTS
//  clock         in   1  system clock, all state on posedge
//  resetn        in   1  asynchronous, active-low reset
//  start_frame   in   1  pulse: render one full frame; ignored unless idle
//  slice_size    in   7  projected wall height from calculator, valid when end_calc=1
//  end_calc      in   1  calculator finished current column (level)
//  column_count  out  8  column under calculation; stable from begin_calc until slice latched
//  begin_calc    out  1  one-cycle request pulse to calculator
//  x             out  8  VGA pixel x (= current column)
//  y             out  7  VGA pixel y
//  colour        out  3  VGA pixel colour
//  plot          out  1  VGA write enable, one pixel per cycle
//  busy          out  1  high from accepted start_frame until frame_done
//  frame_done    out  1  one-cycle pulse after last pixel of last column
//  calc_timeout  out  1  sticky per frame: some column timed out; cleared on start_frame accept
// BEHAVIOUR
//  Reset (async, resetn=0): state S_IDLE; every output 0; column, row, height, timer regs 0.
//  States: S_IDLE -> S_REQ -> S_WAIT -> S_LATCH -> S_DRAW -> S_NEXT -> (S_REQ | S_DONE) -> S_IDLE.
//  S_IDLE: busy=0; start_frame=1 -> column<=0, calc_timeout<=0, go S_REQ.
//  S_REQ: begin_calc=1 for exactly this cycle; timer<=0; -> S_WAIT.
//  S_WAIT: end_calc ignored in first cycle (guard against stale level from prior column);
//   thereafter end_calc=1 -> S_LATCH. timer==CALC_TIMEOUT -> height<=0, calc_timeout<=1, S_DRAW.
//  S_LATCH: height <= min(slice_size, SCREEN_H); top <= (SCREEN_H-height)>>1;
//   bot <= top+height (exclusive); row<=0; -> S_DRAW.
//  S_DRAW: plot=1, x=column, y=row; colour = CEIL if row<top, WALL if top<=row<bot, else FLOOR;
//   row increments each cycle; row==SCREEN_H-1 -> S_NEXT. Exactly SCREEN_H plots per column.
//  S_NEXT: column==NUM_COLS-1 -> S_DONE, else column<=column+1, -> S_REQ.
//  S_DONE: frame_done=1 for one cycle; -> S_IDLE.
//  Outputs x,y,colour registered (plot aligned with them, same cycle). plot=0 outside S_DRAW.
//  Per-column latency: 1 (REQ) + calc cycles + 1 (LATCH) + SCREEN_H (DRAW) + 1 (NEXT).
//  Boundaries: height 0 -> all CEIL/FLOOR, no WALL pixels; slice_size>=SCREEN_H -> full WALL
//   column; odd (SCREEN_H-height) rounds top down; column never wraps past NUM_COLS-1;
//   start_frame while busy ignored; end_calc outside S_WAIT ignored; resetn low mid-frame
//   aborts immediately, no frame_done.
//  Widths: height/top/bot/row 7 bits unsigned, compare unsigned; column 8 bits.
// STRUCTURE
//  raycast_pkg: SCREEN_W/SCREEN_H defaults, colour constants, shared state encoding type.
//  Sub-module slice_span_calc (combinational): height_in -> clamped height, top, bot.
//  Single FSM + datapath in this file; no memories.
// TESTING
//  1 Reset mid-draw: drop resetn during S_DRAW col 5 -> plot,busy,begin_calc 0 same cycle; idle after.
//  2 Model calc answers slice_size=40 after 6 cycles -> col 0: y0-39 CEIL, y40-79 WALL, y80-119 FLOOR.
//  3 slice_size=0 and slice_size=127 -> no WALL pixels / all 120 WALL pixels respectively.
//  4 Full frame, varied latencies -> 160 begin_calc pulses, 19200 plots, one frame_done, x monotone 0..159.
//  5 Calc never asserts end_calc on col 3 -> after 1023 wait cycles col 3 drawn height 0, calc_timeout=1, frame completes.
//  6 end_calc held high from prior column + start_frame pulses while busy -> guard cycle respected, starts ignored.

Source files
------------

// File: rtl/slice_column_sequencer_pkg.sv
// rtl/slice_column_sequencer_pkg.sv - shared constants, state encoding and pixel colour helper
// Purpose: screen geometry defaults, default slice colours, the sequencer state type
//          and the function that picks a pixel colour from its row and the wall span.
// Contents: DEF_SCREEN_W, DEF_SCREEN_H, DEF_*_COLOUR, seq_state_e, span_colour().
package slice_column_sequencer_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] DEF_CEIL_COLOUR  = 3'b001;
  localparam logic [2:0] DEF_WALL_COLOUR  = 3'b111;
  localparam logic [2:0] DEF_FLOOR_COLOUR = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_DRAW  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } seq_state_e;

  // bot is exclusive, so an empty span (top == bot) yields no wall pixels.
  function automatic logic [2:0] span_colour(
    input logic [6:0] row,
    input logic [6:0] top,
    input logic [6:0] bot,
    input logic [2:0] ceil_c,
    input logic [2:0] wall_c,
    input logic [2:0] floor_c
  );
    if (row < top)      return ceil_c;
    else if (row < bot) return wall_c;
    else                return floor_c;
  endfunction

endpackage

// File: rtl/slice_column_sequencer_span_calc.sv
// rtl/slice_column_sequencer_span_calc.sv - clamps a slice height and centres it vertically
// Purpose: combinational wall-span geometry for one screen column.
// Ports:
//   height_i  in  7  requested wall height
//   height_o  out 7  height clamped to SCREEN_H
//   top_o     out 7  first wall row, (SCREEN_H - height) >> 1, odd remainder rounds down
//   bot_o     out 7  first row below the wall (exclusive bound)
module slice_column_sequencer_span_calc #(
  parameter int SCREEN_H = 120
) (
  input  logic [6:0] height_i,
  output logic [6:0] height_o,
  output logic [6:0] top_o,
  output logic [6:0] bot_o
);

  localparam logic [6:0] H = 7'(SCREEN_H);

  assign height_o = (height_i > H) ? H : height_i;
  assign top_o    = (H - height_o) >> 1;
  assign bot_o    = top_o + height_o;

endmodule

// File: rtl/slice_column_sequencer.sv
// rtl/slice_column_sequencer.sv - per-column slice request and vertical slice renderer
// Purpose: walks columns 0..NUM_COLS-1, requests a slice height from the calculator,
//          then streams one column of ceiling / wall / floor pixels to the VGA adapter.
// Ports:
//   clock, resetn        clock; asynchronous active-low reset
//   start_frame    in    pulse, starts a frame when idle
//   slice_size     in 7  calculator result, valid while end_calc is high
//   end_calc       in    calculator done (level)
//   column_count   out 8 column being calculated
//   begin_calc     out   one-cycle calculator request
//   x, y, colour   out   pixel coordinate and colour, qualified by plot
//   plot           out   pixel write enable
//   busy           out   frame in progress
//   frame_done     out   one-cycle end-of-frame pulse
//   calc_timeout   out   some column of this frame timed out waiting for end_calc
import slice_column_sequencer_pkg::*;

module slice_column_sequencer #(
  parameter int         NUM_COLS     = DEF_SCREEN_W,
  parameter int         SCREEN_H     = DEF_SCREEN_H,
  parameter int         CALC_TIMEOUT = 1023,
  parameter logic [2:0] CEIL_COLOUR  = DEF_CEIL_COLOUR,
  parameter logic [2:0] WALL_COLOUR  = DEF_WALL_COLOUR,
  parameter logic [2:0] FLOOR_COLOUR = DEF_FLOOR_COLOUR
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start_frame,
  input  logic [6:0] slice_size,
  input  logic       end_calc,
  output logic [7:0] column_count,
  output logic       begin_calc,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       calc_timeout
);

  localparam int            TW          = $clog2(CALC_TIMEOUT + 1);
  localparam logic [6:0]    LAST_ROW    = 7'(SCREEN_H - 1);
  localparam logic [7:0]    LAST_COL    = 8'(NUM_COLS - 1);
  localparam logic [TW-1:0] TIMEOUT_LIM = TW'(CALC_TIMEOUT);

  seq_state_e    state_q;
  logic [7:0]    column_q;
  logic [6:0]    row_q;
  logic [6:0]    height_q;
  logic [6:0]    top_q;
  logic [6:0]    size_q;
  logic [TW-1:0] timer_q;
  logic          begin_calc_q, plot_q, busy_q, frame_done_q, timeout_q;
  logic [7:0]    x_q;
  logic [6:0]    y_q;
  logic [2:0]    colour_q;

  logic [6:0] row_d;
  logic [7:0] column_d;
  logic [6:0] bot_w;
  logic [6:0] span_in, span_height, span_top, span_bot;
  logic       calc_seen, calc_expired, draw_go;

  assign row_d    = row_q + 7'd1;
  assign column_d = column_q + 8'd1;
  assign bot_w    = top_q + height_q;

  // A timed-out column is drawn with height 0, so the span unit only sees the
  // latched size while in S_LATCH.
  assign span_in = (state_q == S_LATCH) ? size_q : 7'd0;

  slice_column_sequencer_span_calc #(
    .SCREEN_H (SCREEN_H)
  ) u_span (
    .height_i (span_in),
    .height_o (span_height),
    .top_o    (span_top),
    .bot_o    (span_bot)
  );

  // timer_q == 0 marks the first wait cycle: end_calc may still be high from the
  // previous column there, so it is not trusted until the second cycle.
  assign calc_seen    = (timer_q != '0) && end_calc;
  assign calc_expired = !calc_seen && (timer_q == TIMEOUT_LIM);
  assign draw_go      = (state_q == S_LATCH) || ((state_q == S_WAIT) && calc_expired);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      column_q     <= '0;
      row_q        <= '0;
      height_q     <= '0;
      top_q        <= '0;
      size_q       <= '0;
      timer_q      <= '0;
      begin_calc_q <= 1'b0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
    end else begin
      begin_calc_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_frame) begin
            column_q     <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b1;
            begin_calc_q <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_seen) begin
            size_q  <= slice_size;
            state_q <= S_LATCH;
          end else if (calc_expired) begin
            timeout_q <= 1'b1;
            state_q   <= S_DRAW;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_LATCH: begin
          state_q <= S_DRAW;
        end
        S_DRAW: begin
          if (row_q == LAST_ROW) begin
            plot_q  <= 1'b0;
            state_q <= S_NEXT;
          end else begin
            row_q    <= row_d;
            y_q      <= row_d;
            colour_q <= span_colour(row_d, top_q, bot_w, CEIL_COLOUR, WALL_COLOUR, FLOOR_COLOUR);
          end
        end
        S_NEXT: begin
          if (column_q == LAST_COL) begin
            frame_done_q <= 1'b1;
            state_q      <= S_DONE;
          end else begin
            column_q     <= column_d;
            begin_calc_q <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Entering S_DRAW: register the geometry and present row 0 so the first
      // plot cycle already carries a valid pixel.
      if (draw_go) begin
        height_q <= span_height;
        top_q    <= span_top;
        row_q    <= '0;
        plot_q   <= 1'b1;
        x_q      <= column_q;
        y_q      <= '0;
        colour_q <= span_colour(7'd0, span_top, span_bot, CEIL_COLOUR, WALL_COLOUR, FLOOR_COLOUR);
      end
    end
  end

  assign column_count = column_q;
  assign begin_calc   = begin_calc_q;
  assign x            = x_q;
  assign y            = y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign calc_timeout = timeout_q;

endmodule

// File: tb/tb_slice_column_sequencer.sv
// tb/tb_slice_column_sequencer.sv - scoreboard bench for slice_column_sequencer
module tb_slice_column_sequencer;

  localparam int NCOL = 160;
  localparam int SH   = 120;
  localparam int TOUT = 1023;
  localparam logic [2:0] C_CEIL  = 3'b001;
  localparam logic [2:0] C_WALL  = 3'b111;
  localparam logic [2:0] C_FLOOR = 3'b010;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start_frame = 1'b0;
  logic [6:0] slice_size = 7'd0;
  logic       end_calc = 1'b0;
  logic [7:0] column_count;
  logic       begin_calc;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_done, calc_timeout;

  slice_column_sequencer dut (
    .clock        (clock),
    .resetn       (resetn),
    .start_frame  (start_frame),
    .slice_size   (slice_size),
    .end_calc     (end_calc),
    .column_count (column_count),
    .begin_calc   (begin_calc),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .frame_done   (frame_done),
    .calc_timeout (calc_timeout)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  logic [17:0] pix_q[$];
  int          lat_q[$];
  int          lat_tab[NCOL];
  int          size_tab[NCOL];
  int          to_col = -1;
  bit          hold_mode = 1'b0;

  int          cyc = 0;
  int          req_cyc = 0;
  int          n_req = 0;
  int          n_plot = 0;
  int          n_done = 0;
  bit          pending = 1'b0;
  int          cnt = 0;
  logic [6:0]  pend_size = 7'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_colour(input int s, input int r);
    int h, top, bot;
    h   = (s > SH) ? SH : s;
    top = (SH - h) / 2;
    bot = top + h;
    if (r < top) return C_CEIL;
    if (r < bot) return C_WALL;
    return C_FLOOR;
  endfunction

  task automatic push_column(input int col, input int s);
    for (int r = 0; r < SH; r++)
      pix_q.push_back({8'(col), 7'(r), exp_colour(s, r)});
  endtask

  // Calculator model + pixel scoreboard, all on the falling edge.
  always @(negedge clock) begin
    logic [17:0] exp_pix;
    int          exp_lat, c, s, l;
    cyc++;
    if (!resetn) begin
      pix_q.delete();
      lat_q.delete();
      pending  = 1'b0;
      end_calc = 1'b0;
    end else begin
      if (plot) begin
        n_plot++;
        exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : 18'bx;
        check("pixel{x,y,colour}", {14'd0, x, y, colour}, {14'd0, exp_pix});
        if (y == 7'd0) begin
          exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
          check("req_to_first_plot_cycles", cyc - req_cyc, exp_lat);
        end
      end
      if (frame_done) n_done++;
      if (hold_mode && !busy) begin
        end_calc   = 1'b1;
        slice_size = 7'd99;
      end
      if (begin_calc) begin
        n_req++;
        req_cyc = cyc;
        c = int'(column_count);
        if (!hold_mode) end_calc = 1'b0;
        pending = 1'b0;
        if (c == to_col) begin
          push_column(c, 0);
          lat_q.push_back(TOUT + 2);
        end else begin
          s = size_tab[c % NCOL];
          l = lat_tab[c % NCOL];
          push_column(c, s);
          lat_q.push_back(((l < 2) ? 2 : l) + 2);
          if (l == 0) begin
            end_calc   = 1'b1;
            slice_size = 7'(s);
          end else begin
            cnt       = l;
            pend_size = 7'(s);
            pending   = 1'b1;
          end
        end
      end else if (pending) begin
        cnt--;
        if (cnt == 0) begin
          end_calc   = 1'b1;
          slice_size = pend_size;
          pending    = 1'b0;
        end
      end
    end
  end

  initial begin
    int  b_req, b_plot, b_done;
    bit  got;

    for (int c = 0; c < NCOL; c++) begin
      lat_tab[c]  = (c * 7) % 11;
      size_tab[c] = (c * 37 + 11) % 128;
    end
    lat_tab[0] = 6;  size_tab[0] = 40;
    size_tab[1] = 0;
    size_tab[2] = 127;
    size_tab[4] = 41;
    size_tab[5] = 119;
    size_tab[6] = 120;

    // Reset state
    repeat (3) @(negedge clock);
    #1;
    check("reset_plot", plot, 0);
    check("reset_busy", busy, 0);
    check("reset_begin_calc", begin_calc, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_calc_timeout", calc_timeout, 0);
    check("reset_column_count", column_count, 0);
    check("reset_xyc", {x, y, colour}, 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Reset mid-draw on column 5 (columns 0..4 cover 40 / 0 / 127 / timeout-free)
    b_req = n_req; b_done = n_done;
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clock);
      if (plot && x == 8'd5 && y == 7'd10) got = 1'b1;
    end
    check("reach_col5_draw", got, 1);
    check("col0to5_requests", n_req - b_req, 6);
    #2 resetn = 1'b0;
    #1;
    check("abort_plot", plot, 0);
    check("abort_busy", busy, 0);
    check("abort_begin_calc", begin_calc, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    #1;
    check("idle_after_abort_busy", busy, 0);
    check("idle_after_abort_plot", plot, 0);
    check("abort_no_frame_done", n_done - b_done, 0);

    // Full frame: varied latencies, column 3 never answered, starts while busy
    to_col = 3;
    b_req = n_req; b_plot = n_plot; b_done = n_done;
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40000 && !got; i++) begin
      @(negedge clock);
      start_frame = (i == 3000 || i == 12000 || i == 12001);
      if (frame_done) got = 1'b1;
    end
    start_frame = 1'b0;
    check("frame1_done_seen", got, 1);
    check("frame1_calc_timeout", calc_timeout, 1);
    repeat (3) @(negedge clock);
    #1;
    check("frame1_begin_calc_pulses", n_req - b_req, NCOL);
    check("frame1_plots", n_plot - b_plot, NCOL * SH);
    check("frame1_frame_done_cycles", n_done - b_done, 1);
    check("frame1_busy_after", busy, 0);
    check("frame1_pixels_left", pix_q.size(), 0);
    check("frame1_latencies_left", lat_q.size(), 0);

    // Full frame with end_calc held high throughout: guard cycle must hold
    to_col = -1;
    for (int c = 0; c < NCOL; c++) lat_tab[c] = 0;
    hold_mode = 1'b1;
    repeat (2) @(negedge clock);
    b_req = n_req; b_plot = n_plot; b_done = n_done;
    start_frame = 1'b1;
    @(negedge clock);
    start_frame = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("frame2_timeout_cleared", calc_timeout, 0);
    check("frame2_busy", busy, 1);
    got = 1'b0;
    for (int i = 0; i < 40000 && !got; i++) begin
      @(negedge clock);
      if (frame_done) got = 1'b1;
    end
    check("frame2_done_seen", got, 1);
    check("frame2_calc_timeout", calc_timeout, 0);
    repeat (3) @(negedge clock);
    #1;
    check("frame2_begin_calc_pulses", n_req - b_req, NCOL);
    check("frame2_plots", n_plot - b_plot, NCOL * SH);
    check("frame2_frame_done_cycles", n_done - b_done, 1);
    check("frame2_busy_after", busy, 0);
    check("frame2_pixels_left", pix_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
